// File: rtl/regfile_pkg.sv
// Shared types and helpers for the banked multi-write register file.
// Pending slots are sized for the widest supported configuration.
package regfile_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int PEND_AW = 16;
    localparam int PEND_DW = 64;

    typedef struct packed {
        logic               valid;
        logic [PEND_AW-1:0] addr;
        logic [PEND_DW-1:0] data;
    } pend_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int bank_w(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// One register bank: NR combinational read ports, one write port.
module regfile_bank #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 16,
    parameter int RW    = 4,
    parameter int NR    = 4
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [RW-1:0]             wa_i,
    input  logic [WIDTH-1:0]          wd_i,
    input  logic [NR-1:0][RW-1:0]     ra_i,
    output logic [NR-1:0][WIDTH-1:0]  rd_o
);

    logic [WIDTH-1:0] mem_q [ROWS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rd_o[i] = mem_q[ra_i[i]];
        end
    end

endmodule

// File: rtl/banked_regfile_nrmw.sv
// Banked register file, NR reads / NW writes, conflicting writes drained later.
// Define REGFILE_BYPASS_EN to forward committing writes to the read ports.
module banked_regfile_nrmw
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NR    = 4,
    parameter int NW    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NR-1:0][addr_w(DEPTH)-1:0]    ra_i,
    output logic [NR-1:0][WIDTH-1:0]            rd_o,
    input  logic [NW-1:0][addr_w(DEPTH)-1:0]    wa_i,
    input  logic [NW-1:0][WIDTH-1:0]            wd_i,
    input  logic [NW-1:0]                       we_i,
    output logic                                ready_o,
    output logic                                init_done_o
);

    localparam int AW  = addr_w(DEPTH);
    localparam int BW  = bank_w(NW);
    localparam int RW  = AW - BW;
    localparam int RPB = DEPTH / NW;

    state_e              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    pend_t [NW-1:0]      pend_q, pend_d;

    logic [NW-1:0]                  bwe;
    logic [NW-1:0][RW-1:0]          bwa;
    logic [NW-1:0][WIDTH-1:0]       bwd;
    logic [NW-1:0][NR-1:0][WIDTH-1:0] brd;
    logic [NR-1:0][RW-1:0]          ra_row;

    logic          keep;
    logic          any_pend;
    logic [BW-1:0] bsel;
    logic          unused_pend;

    assign unused_pend = ^pend_q;
    assign ready_o     = (state_q == ST_RUN);
    assign init_done_o = (state_q != ST_INIT);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        pend_d   = pend_q;
        bwe      = '0;
        bwa      = '0;
        bwd      = '0;
        keep     = 1'b0;
        bsel     = '0;
        any_pend = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                bwe   = '1;
                for (int b = 0; b < NW; b++) begin
                    bwa[b] = row_q;
                end
                row_d = row_q + 1'b1;
                if (row_q == RW'(RPB - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int p = 0; p < NW; p++) begin
                    // A higher port to the same address supersedes this one
                    keep = we_i[p];
                    for (int q = p + 1; q < NW; q++) begin
                        if (we_i[q] && (wa_i[q] == wa_i[p])) begin
                            keep = 1'b0;
                        end
                    end
                    bsel = wa_i[p][BW-1:0];
                    if (keep && !bwe[bsel]) begin
                        bwe[bsel] = 1'b1;
                        bwa[bsel] = wa_i[p][AW-1:BW];
                        bwd[bsel] = wd_i[p];
                    end else if (keep) begin
                        pend_d[p].valid = 1'b1;
                        pend_d[p].addr  = PEND_AW'(wa_i[p]);
                        pend_d[p].data  = PEND_DW'(wd_i[p]);
                        state_d         = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                for (int p = 0; p < NW; p++) begin
                    bsel = pend_q[p].addr[BW-1:0];
                    if (pend_q[p].valid && !bwe[bsel]) begin
                        bwe[bsel]       = 1'b1;
                        bwa[bsel]       = pend_q[p].addr[AW-1:BW];
                        bwd[bsel]       = pend_q[p].data[WIDTH-1:0];
                        pend_d[p].valid = 1'b0;
                    end
                    any_pend = any_pend | pend_d[p].valid;
                end
                if (!any_pend) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            row_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            ra_row[i] = ra_i[i][AW-1:BW];
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_bank
        regfile_bank #(
            .WIDTH (WIDTH),
            .ROWS  (RPB),
            .RW    (RW),
            .NR    (NR)
        ) u_bank (
            .clk   (clk),
            .we_i  (bwe[g]),
            .wa_i  (bwa[g]),
            .wd_i  (bwd[g]),
            .ra_i  (ra_row),
            .rd_o  (brd[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rd_o[i] = brd[ra_i[i][BW-1:0]][i];
`ifdef REGFILE_BYPASS_EN
            // Address fixes the bank, so at most one committer can match
            if (init_done_o && bwe[ra_i[i][BW-1:0]] &&
                (bwa[ra_i[i][BW-1:0]] == ra_row[i])) begin
                rd_o[i] = bwd[ra_i[i][BW-1:0]];
            end
`endif
        end
    end

endmodule

// File: tb/tb_banked_regfile_nrmw.sv
// Directed self-checking bench for banked_regfile_nrmw (default parameters).
module tb_banked_regfile_nrmw;

    logic                 clk;
    logic                 rst_n;
    logic [3:0][4:0]      ra_i;
    logic [3:0][31:0]     rd_o;
    logic [1:0][4:0]      wa_i;
    logic [1:0][31:0]     wd_i;
    logic [1:0]           we_i;
    logic                 ready_o;
    logic                 init_done_o;

    int checks;
    int failures;

    banked_regfile_nrmw dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ra_i        (ra_i),
        .rd_o        (rd_o),
        .wa_i        (wa_i),
        .wd_i        (wd_i),
        .we_i        (we_i),
        .ready_o     (ready_o),
        .init_done_o (init_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        ra_i[0] = a;
        #1;
        d = rd_o[0];
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        we_i  = '0;
        wa_i  = '0;
        wd_i  = '0;
        ra_i  = '0;
        repeat (2) tick();
        checks++;
        if (ready_o !== 1'b0 || init_done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: ready=%b done=%b want 0 0", ready_o, init_done_o);
        end
        rst_n = 1'b1;
        repeat (15) tick();
        checks++;
        if (init_done_o !== 1'b0 || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL init_len15: ready=%b done=%b want 0 0", ready_o, init_done_o);
        end
        tick();
        checks++;
        if (init_done_o !== 1'b1 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL init_len16: ready=%b done=%b want 1 1", ready_o, init_done_o);
        end
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL init_zero a=%0d: got %h want 0", a, d);
            end
        end
    endtask

    task automatic test_distinct_banks();
        logic [31:0] d;
        we_i = 2'b11;
        wa_i[0] = 5'd2;
        wd_i[0] = 32'hAAAA;
        wa_i[1] = 5'd3;
        wd_i[1] = 32'h5555;
        tick();
        we_i = '0;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL distinct_ready: got %b want 1", ready_o);
        end
        rd(5'd2, d);
        checks++;
        if (d !== 32'hAAAA) begin
            failures++;
            $display("FAIL distinct_a2: got %h want aaaa", d);
        end
        rd(5'd3, d);
        checks++;
        if (d !== 32'h5555) begin
            failures++;
            $display("FAIL distinct_a3: got %h want 5555", d);
        end
    endtask

    task automatic test_bank_conflict();
        logic [31:0] d;
        logic [31:0] exp6;
        we_i = 2'b11;
        wa_i[0] = 5'd4;
        wd_i[0] = 32'h11;
        wa_i[1] = 5'd6;
        wd_i[1] = 32'h22;
        tick();
        // DRAIN cycle: this write must be ignored
        we_i = 2'b01;
        wa_i[0] = 5'd20;
        wd_i[0] = 32'h99;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL conflict_ready0: got %b want 0", ready_o);
        end
        rd(5'd4, d);
        checks++;
        if (d !== 32'h11) begin
            failures++;
            $display("FAIL conflict_a4: got %h want 11", d);
        end
`ifdef REGFILE_BYPASS_EN
        exp6 = 32'h22;
`else
        exp6 = 32'h0;
`endif
        rd(5'd6, d);
        checks++;
        if (d !== exp6) begin
            failures++;
            $display("FAIL conflict_a6_drain: got %h want %h", d, exp6);
        end
        tick();
        we_i = '0;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL conflict_ready1: got %b want 1", ready_o);
        end
        rd(5'd6, d);
        checks++;
        if (d !== 32'h22) begin
            failures++;
            $display("FAIL conflict_a6: got %h want 22", d);
        end
        rd(5'd20, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL ignored_we_a20: got %h want 0", d);
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] d;
        we_i = 2'b11;
        wa_i[0] = 5'd8;
        wd_i[0] = 32'h1;
        wa_i[1] = 5'd8;
        wd_i[1] = 32'h2;
        tick();
        we_i = '0;
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL same_ready0: got %b want 1", ready_o);
        end
        rd(5'd8, d);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("FAIL same_a8: got %h want 2", d);
        end
        tick();
        checks++;
        if (ready_o !== 1'b1) begin
            failures++;
            $display("FAIL same_ready1: got %b want 1", ready_o);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 32'h77;
`else
        exp = 32'h0;
`endif
        ra_i[1] = 5'd10;
        we_i = 2'b01;
        wa_i[0] = 5'd10;
        wd_i[0] = 32'h77;
        #1;
        checks++;
        if (rd_o[1] !== exp) begin
            failures++;
            $display("FAIL bypass_same_cycle: got %h want %h", rd_o[1], exp);
        end
        tick();
        we_i = '0;
        checks++;
        if (rd_o[1] !== 32'h77) begin
            failures++;
            $display("FAIL bypass_after: got %h want 77", rd_o[1]);
        end
    endtask

    task automatic test_reset_in_drain();
        logic [31:0] d;
        int n;
        we_i = 2'b11;
        wa_i[0] = 5'd12;
        wd_i[0] = 32'h33;
        wa_i[1] = 5'd14;
        wd_i[1] = 32'h44;
        tick();
        we_i = '0;
        checks++;
        if (ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rdrain_in_drain: ready=%b want 0", ready_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || init_done_o !== 1'b0) begin
            failures++;
            $display("FAIL rdrain_flags: ready=%b done=%b want 0 0", ready_o, init_done_o);
        end
        tick();
        rst_n = 1'b1;
        n = 0;
        while (init_done_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL rdrain_init_cycles: got %0d want 16", n);
        end
        rd(5'd14, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rdrain_a14: got %h want 0", d);
        end
        rd(5'd12, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rdrain_a12: got %h want 0", d);
        end
        rd(5'd2, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rdrain_a2: got %h want 0", d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_distinct_banks();
        test_bank_conflict();
        test_same_addr();
        test_bypass();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
